// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing main memory between the I and D cache ports
module mem_arbiter #(
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_enable_i,
  input  logic              i_write_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic [DATA_W-1:0] i_data_i,
  output logic              i_ack_o,
  output logic [DATA_W-1:0] i_data_o,
  input  logic              d_enable_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o,
  output logic              owner_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYC - 1);

  stateT              state, stateNext;
  logic               memEnable, memEnableNext;
  logic               memWrite, memWriteNext;
  logic [ADDR_W-1:0]  memAddr, memAddrNext;
  logic [DATA_W-1:0]  memData, memDataNext;
  logic [DATA_W-1:0]  respData, respDataNext;
  logic               owner, ownerNext;
  logic               err, errNext;
  logic               iAck, iAckNext;
  logic               dAck, dAckNext;
  logic [15:0]        waitCnt, waitCntNext;
  logic               grantD;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      memEnable <= 1'b0;
      memWrite  <= 1'b0;
      memAddr   <= '0;
      memData   <= '0;
      respData  <= '0;
      owner     <= 1'b0;
      err       <= 1'b0;
      iAck      <= 1'b0;
      dAck      <= 1'b0;
      waitCnt   <= '0;
    end else begin
      state     <= stateNext;
      memEnable <= memEnableNext;
      memWrite  <= memWriteNext;
      memAddr   <= memAddrNext;
      memData   <= memDataNext;
      respData  <= respDataNext;
      owner     <= ownerNext;
      err       <= errNext;
      iAck      <= iAckNext;
      dAck      <= dAckNext;
      waitCnt   <= waitCntNext;
    end
  end

  always_comb begin
    stateNext     = state;
    memEnableNext = memEnable;
    memWriteNext  = memWrite;
    memAddrNext   = memAddr;
    memDataNext   = memData;
    respDataNext  = respData;
    ownerNext     = owner;
    errNext       = err;
    iAckNext      = 1'b0;
    dAckNext      = 1'b0;
    waitCntNext   = waitCnt;
    // D wins when it is the only requester or when I held the last grant
    grantD        = d_enable_i && (!i_enable_i || !owner);

    case (state)
      IDLE: begin
        if (i_enable_i || d_enable_i) begin
          stateNext     = BUSY;
          memEnableNext = 1'b1;
          ownerNext     = grantD;
          memWriteNext  = grantD ? d_write_i : i_write_i;
          memAddrNext   = grantD ? d_addr_i  : i_addr_i;
          memDataNext   = grantD ? d_data_i  : i_data_i;
          waitCntNext   = '0;
        end
      end
      BUSY: begin
        waitCntNext = waitCnt + 16'd1;
        // An ack arriving on the timeout cycle still counts as success
        if (mem_ack_i) begin
          stateNext     = RESP;
          memEnableNext = 1'b0;
          respDataNext  = mem_data_i;
          iAckNext      = !owner;
          dAckNext      = owner;
        end else if (waitCnt == LAST_WAIT) begin
          stateNext     = RESP;
          memEnableNext = 1'b0;
          respDataNext  = '0;
          errNext       = 1'b1;
          iAckNext      = !owner;
          dAckNext      = owner;
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext     = IDLE;
        memEnableNext = 1'b0;
      end
    endcase
  end

  assign mem_enable_o = memEnable;
  assign mem_write_o  = memWrite;
  assign mem_addr_o   = memAddr;
  assign mem_data_o   = memData;
  assign i_ack_o      = iAck;
  assign d_ack_o      = dAck;
  assign i_data_o     = respData;
  assign d_data_o     = respData;
  assign busy_o       = (state != IDLE);
  assign owner_o      = owner;
  assign err_o        = err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         i_enable_i, i_write_i, d_enable_i, d_write_i;
  logic [31:0]  i_addr_i, d_addr_i;
  logic [255:0] i_data_i, d_data_i;
  logic         i_ack_o, d_ack_o;
  logic [255:0] i_data_o, d_data_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;
  logic         busy_o, owner_o, err_o;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(256), .ADDR_W(32), .TIMEOUT_CYC(64)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_enable_i(i_enable_i), .i_write_i(i_write_i), .i_addr_i(i_addr_i), .i_data_i(i_data_i),
    .i_ack_o(i_ack_o), .i_data_o(i_data_o),
    .d_enable_i(d_enable_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i), .d_data_i(d_data_i),
    .d_ack_o(d_ack_o), .d_data_o(d_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
    .busy_o(busy_o), .owner_o(owner_o), .err_o(err_o)
  );

  task automatic doReset();
    rst_i = 1'b1;
    i_enable_i = 0; i_write_i = 0; i_addr_i = '0; i_data_i = '0;
    d_enable_i = 0; d_write_i = 0; d_addr_i = '0; d_data_i = '0;
    mem_ack_i = 0; mem_data_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
  endtask

  // Memory model: answers after 'latency' enable cycles (0 = never) and records what it saw
  task automatic memServe(input int latency, input logic [255:0] rdata, input bit flipData,
                          output int waitCyc, output int enCycles, output logic ownerSeen,
                          output logic wrSeen, output logic [31:0] addrSeen,
                          output logic [255:0] wdSeen, output bit stable,
                          output int iAcks, output int dAcks,
                          output logic [255:0] iDat, output logic [255:0] dDat);
    waitCyc = 0; enCycles = 0; stable = 1; iAcks = 0; dAcks = 0;
    iDat = '0; dDat = '0; ownerSeen = 0; wrSeen = 0; addrSeen = '0; wdSeen = '0;
    mem_data_i = rdata;
    do begin
      @(negedge clk);
      waitCyc++;
    end while (!mem_enable_o && waitCyc < 20);
    while (mem_enable_o && enCycles < 300) begin
      enCycles++;
      if (enCycles == 1) begin
        ownerSeen = owner_o; wrSeen = mem_write_o; addrSeen = mem_addr_o; wdSeen = mem_data_o;
      end else if ({mem_write_o, mem_addr_o, mem_data_o} !== {wrSeen, addrSeen, wdSeen}) begin
        stable = 0;
      end
      if (flipData && enCycles == 3) begin
        i_data_i = ~i_data_i;
        d_data_i = ~d_data_i;
      end
      mem_ack_i = (latency != 0 && enCycles == latency);
      @(negedge clk);
    end
    mem_ack_i = 0;
    for (int k = 0; k < 2; k++) begin
      if (i_ack_o) begin iAcks++; iDat = i_data_o; end
      if (d_ack_o) begin dAcks++; dDat = d_data_o; end
      if (k == 0) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    doReset();
    @(negedge clk);
    nCompared++;
    if ({mem_enable_o, mem_write_o, i_ack_o, d_ack_o, busy_o, owner_o, err_o} !== 7'b0) begin
      nMismatched++;
      $display("FAIL reset_flags: got %b want 0000000",
               {mem_enable_o, mem_write_o, i_ack_o, d_ack_o, busy_o, owner_o, err_o});
    end
    nCompared++;
    if ({mem_addr_o, mem_data_o, i_data_o} !== '0) begin
      nMismatched++;
      $display("FAIL reset_data: addr %h wdata %h rdata %h want all 0", mem_addr_o, mem_data_o, i_data_o);
    end
  endtask

  task automatic test_single_read();
    int w, en, ia, da; logic ow, wr; logic [31:0] ad; logic [255:0] wd, id, dd; bit st;
    i_enable_i = 1; i_write_i = 0; i_addr_i = 32'h100;
    memServe(10, {32{8'hA5}}, 0, w, en, ow, wr, ad, wd, st, ia, da, id, dd);
    i_enable_i = 0;
    nCompared++; if (w !== 1) begin nMismatched++; $display("FAIL read_grant_latency: got %0d want 1", w); end
    nCompared++; if (en !== 10) begin nMismatched++; $display("FAIL read_enable_cycles: got %0d want 10", en); end
    nCompared++; if (ad !== 32'h100 || wr !== 1'b0 || !st) begin
      nMismatched++; $display("FAIL read_cmd: addr %h wr %b stable %0d want 100 0 1", ad, wr, st); end
    nCompared++; if (ia !== 1 || da !== 0) begin
      nMismatched++; $display("FAIL read_acks: i %0d d %0d want 1 0", ia, da); end
    nCompared++; if (id !== {32{8'hA5}}) begin
      nMismatched++; $display("FAIL read_data: got %h want a5..a5", id); end
  endtask

  task automatic test_contention();
    int w, en, ia, da; logic ow, wr; logic [31:0] ad; logic [255:0] wd, id, dd; bit st;
    doReset();
    @(negedge clk);
    i_enable_i = 1; i_write_i = 0; i_addr_i = 32'h200;
    d_enable_i = 1; d_write_i = 0; d_addr_i = 32'h300;
    memServe(3, 256'h11, 0, w, en, ow, wr, ad, wd, st, ia, da, id, dd);
    d_enable_i = 0;
    nCompared++; if (ow !== 1'b1 || ad !== 32'h300) begin
      nMismatched++; $display("FAIL contention_first: owner %b addr %h want 1 300", ow, ad); end
    nCompared++; if (da !== 1 || ia !== 0 || dd !== 256'h11) begin
      nMismatched++; $display("FAIL contention_first_ack: d %0d i %0d data %h want 1 0 11", da, ia, dd); end
    memServe(3, 256'h22, 0, w, en, ow, wr, ad, wd, st, ia, da, id, dd);
    i_enable_i = 0;
    nCompared++; if (ow !== 1'b0 || ad !== 32'h200 || w !== 1) begin
      nMismatched++; $display("FAIL contention_second: owner %b addr %h wait %0d want 0 200 1", ow, ad, w); end
    nCompared++; if (ia !== 1 || da !== 0 || id !== 256'h22) begin
      nMismatched++; $display("FAIL contention_second_ack: i %0d d %0d data %h want 1 0 22", ia, da, id); end
  endtask

  task automatic test_back_to_back();
    int w, en, ia, da; logic ow, wr; logic [31:0] ad; logic [255:0] wd, id, dd; bit st;
    logic expD;
    i_enable_i = 1; i_write_i = 0; i_addr_i = 32'h800;
    d_enable_i = 1; d_write_i = 0; d_addr_i = 32'h900;
    for (int k = 0; k < 6; k++) begin
      expD = (k % 2 == 0);
      memServe(2, 256'(k + 7), 0, w, en, ow, wr, ad, wd, st, ia, da, id, dd);
      nCompared++; if (ow !== expD || ad !== (expD ? 32'h900 : 32'h800) || w !== 1) begin
        nMismatched++; $display("FAIL b2b_grant_%0d: owner %b addr %h wait %0d want %b", k, ow, ad, w, expD); end
      nCompared++; if (ia !== (expD ? 0 : 1) || da !== (expD ? 1 : 0)
                       || (expD ? dd : id) !== 256'(k + 7)) begin
        nMismatched++; $display("FAIL b2b_ack_%0d: i %0d d %0d want d=%b data %0d", k, ia, da, expD, k + 7); end
    end
    i_enable_i = 0; d_enable_i = 0;
  endtask

  task automatic test_write();
    int w, en, ia, da; logic ow, wr; logic [31:0] ad; logic [255:0] wd, id, dd; bit st;
    @(negedge clk);
    d_enable_i = 1; d_write_i = 1; d_addr_i = 32'h400; d_data_i = 256'h1234;
    memServe(6, 256'h0, 1, w, en, ow, wr, ad, wd, st, ia, da, id, dd);
    d_enable_i = 0; d_write_i = 0;
    nCompared++; if (wr !== 1'b1 || ad !== 32'h400 || wd !== 256'h1234) begin
      nMismatched++; $display("FAIL write_cmd: wr %b addr %h data %h want 1 400 1234", wr, ad, wd); end
    nCompared++; if (!st || en !== 6) begin
      nMismatched++; $display("FAIL write_stable: stable %0d cycles %0d want 1 6", st, en); end
    nCompared++; if (da !== 1 || ia !== 0) begin
      nMismatched++; $display("FAIL write_ack: d %0d i %0d want 1 0", da, ia); end
  endtask

  task automatic test_timeout();
    int w, en, ia, da; logic ow, wr; logic [31:0] ad; logic [255:0] wd, id, dd; bit st;
    i_enable_i = 1; i_write_i = 0; i_addr_i = 32'h500;
    memServe(0, {256{1'b1}}, 0, w, en, ow, wr, ad, wd, st, ia, da, id, dd);
    i_enable_i = 0;
    nCompared++; if (en !== 64) begin nMismatched++; $display("FAIL timeout_cycles: got %0d want 64", en); end
    nCompared++; if (ia !== 1 || da !== 0 || id !== '0) begin
      nMismatched++; $display("FAIL timeout_ack: i %0d d %0d data %h want 1 0 0", ia, da, id); end
    nCompared++; if (err_o !== 1'b1) begin nMismatched++; $display("FAIL timeout_err: got %b want 1", err_o); end
    i_enable_i = 1; i_addr_i = 32'h510;
    memServe(3, 256'h55, 0, w, en, ow, wr, ad, wd, st, ia, da, id, dd);
    i_enable_i = 0;
    nCompared++; if (err_o !== 1'b1 || id !== 256'h55) begin
      nMismatched++; $display("FAIL timeout_sticky: err %b data %h want 1 55", err_o, id); end
    doReset();
    @(negedge clk);
    nCompared++; if (err_o !== 1'b0) begin nMismatched++; $display("FAIL timeout_clear: got %b want 0", err_o); end
  endtask

  task automatic test_reset_mid();
    int w, en, ia, da, cnt; logic ow, wr; logic [31:0] ad; logic [255:0] wd, id, dd; bit st;
    i_enable_i = 1; i_write_i = 0; i_addr_i = 32'h600;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!mem_enable_o && cnt < 20);
    repeat (2) @(negedge clk);
    rst_i = 1;
    @(negedge clk);
    nCompared++;
    if ({mem_enable_o, busy_o, i_ack_o, d_ack_o, owner_o, err_o, mem_write_o} !== 7'b0 || mem_addr_o !== '0) begin
      nMismatched++;
      $display("FAIL midreset_state: flags %b addr %h want 0 0",
               {mem_enable_o, busy_o, i_ack_o, d_ack_o, owner_o, err_o, mem_write_o}, mem_addr_o);
    end
    rst_i = 0; i_enable_i = 0;
    repeat (4) @(negedge clk);
    mem_data_i = 256'hDEAD; mem_ack_i = 1;
    @(negedge clk);
    mem_ack_i = 0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (i_ack_o || d_ack_o || busy_o || mem_enable_o) cnt++;
    end
    nCompared++; if (cnt !== 0) begin nMismatched++; $display("FAIL midreset_stray_ack: active cycles %0d want 0", cnt); end
    d_enable_i = 1; d_write_i = 0; d_addr_i = 32'h700;
    memServe(4, 256'hBEEF, 0, w, en, ow, wr, ad, wd, st, ia, da, id, dd);
    d_enable_i = 0;
    nCompared++; if (da !== 1 || ia !== 0 || dd !== 256'hBEEF || ad !== 32'h700 || en !== 4) begin
      nMismatched++; $display("FAIL midreset_recover: d %0d i %0d data %h addr %h cycles %0d want 1 0 beef 700 4",
                              da, ia, dd, ad, en); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_write();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
